// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Supports a lock for atomic sequences and routes each read's return data to its issuer.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

    state_t                state, state_nxt;
    logic                  ptr, ptr_nxt;
    logic                  g0, g1;
    logic                  rd_pend, rd_port;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] data_hold;

    // ptr names the port that wins a tie; it always points away from the last ARB grant.
    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ARB: begin
                if (req0 && (!req1 || !ptr)) g0 = 1'b1;
                else if (req1)               g1 = 1'b1;
                if (g0) begin
                    ptr_nxt = 1'b1;
                    if (lock0) state_nxt = OWN0;
                end else if (g1) begin
                    ptr_nxt = 1'b0;
                    if (lock1) state_nxt = OWN1;
                end
            end
            OWN0: begin
                g0 = req0;
                if (!lock0) begin
                    state_nxt = ARB;
                    ptr_nxt   = 1'b1;
                end
            end
            OWN1: begin
                g1 = req1;
                if (!lock1) begin
                    state_nxt = ARB;
                    ptr_nxt   = 1'b0;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (reset) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;

    // With no grant the RAM address/data hold their last driven values.
    always_comb begin
        mem_wren    = 1'b0;
        mem_address = addr_hold;
        mem_data    = data_hold;
        if (g0) begin
            mem_wren    = we0;
            mem_address = addr0;
            mem_data    = wdata0;
        end else if (g1) begin
            mem_wren    = we1;
            mem_address = addr1;
            mem_data    = wdata1;
        end
        if (reset) begin
            mem_address = '0;
            mem_data    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            ptr       <= 1'b0;
            rd_pend   <= 1'b0;
            rd_port   <= 1'b0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            rd_pend <= (g0 && !we0) || (g1 && !we1);
            rd_port <= g1;
            if (g0 || g1) begin
                addr_hold <= mem_address;
                data_hold <= mem_data;
            end
        end
    end

    assign rvalid0 = rd_pend && !rd_port;
    assign rvalid1 = rd_pend && rd_port;
    assign rdata0  = rvalid0 ? mem_q : '0;
    assign rdata1  = rvalid1 ? mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into a queue,
// and a negedge monitor pops and compares them whenever an rvalid appears.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
    logic [15:0] rdata0, rdata1, mem_address, mem_data, mem_q;

    logic [15:0] ram [0:65535];
    logic        init_ram;
    logic [16:0] exp_q [$];
    logic [16:0] mon_e;
    int          passed = 0;
    int          total  = 0;

    mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM, read data one cycle after the address.
    always @(posedge clock) begin
        if (init_ram) begin
            ram[16'h0001] <= 16'h1111;
            ram[16'h0002] <= 16'h2222;
            ram[16'h0005] <= 16'h0055;
            ram[16'h0007] <= 16'h7777;
            ram[16'h0010] <= 16'hBEEF;
            ram[16'h0040] <= 16'h0000;
            ram[16'hFFFF] <= 16'hF00D;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        mem_q <= ram[mem_address];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clock) begin
        if (rvalid0 || rvalid1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL rvalid: unexpected rvalid0=%0b rvalid1=%0b expected none", rvalid0, rvalid1);
            end else begin
                mon_e = exp_q.pop_front();
                check("rvalid port", {30'd0, rvalid1, rvalid0}, mon_e[16] ? 32'd2 : 32'd1);
                check("rdata", mon_e[16] ? rdata1 : rdata0, {16'd0, mon_e[15:0]});
                check("other rdata", mon_e[16] ? rdata0 : rdata1, 32'd0);
            end
        end
    end

    task automatic set0(input bit r, input bit w, input bit l, input logic [15:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input bit r, input bit w, input bit l, input logic [15:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    // One cycle: inputs were set after the previous edge; check grants mid-cycle.
    task automatic step(input bit eg0, input bit eg1, input logic [15:0] edat, input string nm);
        @(negedge clock);
        check({nm, " gnt0"}, gnt0, eg0);
        check({nm, " gnt1"}, gnt1, eg1);
        check({nm, " wren"}, mem_wren, eg0 ? we0 : (eg1 ? we1 : 1'b0));
        if (eg0 || eg1) begin
            check({nm, " addr"}, mem_address, eg0 ? addr0 : addr1);
            if (eg0 ? we0 : we1) check({nm, " wdata"}, mem_data, eg0 ? wdata0 : wdata1);
            else exp_q.push_back({eg1, edat});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        init_ram = 1'b1;
        set0(1, 1, 0, 16'h1234, 16'hDEAD);
        set1(0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clock);
        check("rst gnt0", gnt0, 0);
        check("rst gnt1", gnt1, 0);
        check("rst wren", mem_wren, 0);
        check("rst addr", mem_address, 0);
        check("rst data", mem_data, 0);
        check("rst rvalid", {rvalid1, rvalid0}, 0);
        @(posedge clock);
        #1;
        init_ram = 1'b0;
        reset = 1'b0;

        // Contention from reset: strict alternation starting at port 0.
        set0(1, 0, 0, 16'h0001, 0);
        set1(1, 0, 0, 16'h0002, 0);
        step(1, 0, 16'h1111, "rr0");
        step(0, 1, 16'h2222, "rr1");
        step(1, 0, 16'h1111, "rr2");
        step(0, 1, 16'h2222, "rr3");

        // Locked read-modify-write by port 0 while port 1 waits.
        set0(1, 0, 1, 16'h0005, 0);
        step(1, 0, 16'h0055, "lock rd");
        set0(1, 1, 1, 16'h0005, 16'h00AA);
        step(1, 0, 16'h0000, "lock wr");
        set0(1, 0, 0, 16'h0005, 0);
        step(1, 0, 16'h00AA, "lock last");
        set0(1, 0, 0, 16'h0010, 0);
        step(0, 1, 16'h2222, "unlock");
        set1(0, 0, 0, 16'h0000, 0);
        step(1, 0, 16'hBEEF, "rd 0010");
        set0(0, 0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, "idle 0");

        // Write then immediate read of the same address from the other port.
        set1(1, 1, 0, 16'h0040, 16'h1234);
        step(0, 1, 16'h0000, "wr 0040");
        set1(0, 0, 0, 16'h0000, 0);
        set0(1, 0, 0, 16'h0040, 0);
        step(1, 0, 16'h1234, "rd 0040");
        set0(1, 0, 0, 16'hFFFF, 0);
        step(1, 0, 16'hF00D, "rd ffff");

        // Reset right after a locked read: return is dropped, lock and pointer cleared.
        set0(0, 0, 0, 16'h0000, 0);
        set1(1, 0, 1, 16'h0007, 0);
        step(0, 1, 16'h7777, "rd 0007");
        void'(exp_q.pop_back());
        reset = 1'b1;
        set0(1, 0, 0, 16'h0001, 0);
        set1(1, 0, 0, 16'h0002, 0);
        @(negedge clock);
        check("mid rst gnt", {gnt1, gnt0}, 0);
        check("mid rst rvalid1", rvalid1, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1, 0, 16'h1111, "post rst 0");
        step(0, 1, 16'h2222, "post rst 1");

        // Idle: no activity, address holds, RAM untouched.
        set0(0, 0, 0, 16'h0000, 0);
        set1(0, 0, 0, 16'h0000, 0);
        repeat (3) step(0, 0, 16'h0000, "idle");
        @(negedge clock);
        check("idle addr hold", mem_address, 16'h0002);
        check("ram 0040", ram[16'h0040], 16'h1234);
        check("ram 0005", ram[16'h0005], 16'h00AA);
        check("ram 0010", ram[16'h0010], 16'hBEEF);
        check("ram 0007", ram[16'h0007], 16'h7777);
        repeat (2) @(posedge clock);
        #1;
        check("pending reads", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port synchronous RAM (`memory`) between requesters 0 and 1.
  - Port 0: processor load/store unit.
  - Port 1: secondary master, e.g. I/O, DMA or video fetch.
- Issues at most one access per cycle. Fairness is round-robin.
- Supports an optional lock so one port can hold the RAM across consecutive accesses (atomic read-modify-write).
- Routes each read's return data back to the port that issued it, with fixed one-cycle read latency.

Parameters:
- DATA_WIDTH, 16, word width of write and read data.
- ADDR_WIDTH, 16, word address width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0/req1  input  1  access request; held with its fields until granted.
- we0/we1  input  1  1 = write, 0 = read; valid while req is high.
- addr0/addr1  input  ADDR_WIDTH  word address.
- wdata0/wdata1  input  DATA_WIDTH  write data.
- lock0/lock1  input  1  keep ownership after this grant while high.
- gnt0/gnt1  output  1  access accepted this cycle (combinational).
- rvalid0/rvalid1  output  1  read data valid this cycle (registered).
- rdata0/rdata1  output  DATA_WIDTH  read data; equals mem_q when the matching rvalid is high, otherwise 0.
- mem_address  output  ADDR_WIDTH  to RAM address.
- mem_data  output  DATA_WIDTH  to RAM data.
- mem_wren  output  1  to RAM write enable.
- mem_q  input  DATA_WIDTH  from RAM; valid one cycle after the address is presented.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to ARB; priority pointer goes to port 0.
  - rd_pend = 0; rvalid0 = rvalid1 = 0.
  - While reset is high, gnt0/gnt1 and mem_wren are forced to 0 and mem_address/mem_data to 0.
- State machine states: ARB, OWN0, OWN1.
- ARB:
  - Only one request: that port is granted.
  - Both request: the port selected by the priority pointer is granted. The pointer always names the port not granted most recently; it flips to the other port after each grant.
  - No request: no grant; mem_wren = 0; mem_address holds its last driven value.
- OWN<n>:
  - Only port n can be granted; the other port's request is stalled with gnt = 0.
  - Pointer is not updated on grants made while in OWN.
- Transitions:
  - ARB→OWN<n> when port n is granted with lock<n> = 1.
  - OWN<n>→ARB at the first edge where lock<n> = 0. This happens whether or not a final grant occurs in that cycle; a grant in that same cycle is still issued.
  - After OWN<n>→ARB, the pointer names the other port.
- Grant cycle:
  - mem_address, mem_data and mem_wren = we are driven combinationally from the granted port.
  - The RAM write takes effect at that edge.
  - gnt is high for exactly the cycles in which an access is issued.
  - A requester holding req high across cycles receives one grant per cycle it wins.
- Read return:
  - A granted read sets rd_pend = 1 and rd_port = n at the edge.
  - In the following cycle rvalid<rd_port> = 1 and rdata<rd_port> = mem_q.
  - Back-to-back reads give rvalid every cycle, in issue order.
  - A granted write produces no rvalid.
- Simultaneous events:
  - A grant issued in the same cycle as a pending read return is permitted; the two overlap with no bubble.
  - A write to address A followed next cycle by a read of A returns the new data.
- Reset mid-operation: any pending read is discarded (no rvalid), and any lock is dropped.
- Width rule: addresses are word addresses with no wrap or offset arithmetic; all ADDR_WIDTH bits pass through unchanged.
- Latency: grant 0 cycles after req when the port wins; read data 1 cycle after grant.

Test Plan:
- req0 read addr 0x0010, RAM preloaded 0x0010 = 0xBEEF -> gnt0 in the same cycle, next cycle rvalid0 = 1 and rdata0 = 0xBEEF; rvalid1 stays 0.
- req0 and req1 both held high for 4 cycles after reset (reads of 0x0001 and 0x0002) -> grant order 0,1,0,1; rvalid alternates one cycle later; data matches each port's address.
- Port 1 write 0x1234 to 0x0040, then port 0 read 0x0040 on the next cycle -> rdata0 = 0x1234.
- Port 0 lock0 = 1: read 0x0005 then write 0x0005 = 0x00AA while req1 is held -> gnt1 = 0 during both cycles; after lock0 drops, gnt1 on the next cycle; a final read of 0x0005 returns 0x00AA.
- Reset asserted in the cycle after a granted read of 0x0007 -> no rvalid for that read; after release the pointer is 0 and both req give gnt0 first.
- Idle (no req) for 3 cycles -> mem_wren = 0, no gnt, no rvalid; RAM contents unchanged.
